fp32_accumulator: RTL and testbench

FP32_ACCUMULATOR -- requirements
Module: fp32_accumulator

---
 rtl/fp32_accumulator.sv | 192 +++++++++++++++++++
 tb/tb_fp32_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fp32_accumulator.sv
// FP32 accumulator: sums LEN single-precision terms through one combinational adder.
// Optional synchronous flush input is enabled by defining FP32_ACC_FLUSH_EN.

module FP_Adder_Subtractor32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    output logic [31:0] Out,
    output logic        isZero
);
    logic        sa, sb, sx;
    logic [7:0]  ex, ey, d;
    logic [26:0] ma, mb, mx, my, my_sh, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n;
    logic [24:0] mant;
    logic        inc;

    always_comb begin
        sa     = A[31];
        sb     = B[31] ^ sub;
        ma     = {A[30:23] != 8'd0, A[22:0], 3'b000};
        mb     = {B[30:23] != 8'd0, B[22:0], 3'b000};
        sx     = sa;
        ex     = A[30:23];
        ey     = B[30:23];
        mx     = ma;
        my     = mb;
        my_sh  = '0;
        sum    = '0;
        norm   = '0;
        lz     = 5'd27;
        exp_n  = '0;
        mant   = '0;
        inc    = 1'b0;
        d      = '0;
        Out    = '0;
        isZero = 1'b0;

        // Larger magnitude goes to x so the aligned difference is never negative.
        if (B[30:0] > A[30:0]) begin
            sx = sb;
            ex = B[30:23];
            ey = A[30:23];
            mx = mb;
            my = ma;
        end
        d = ex - ey;
        if (d >= 8'd27)
            my_sh = {26'd0, |my};
        else begin
            my_sh    = my >> d;
            my_sh[0] = my_sh[0] | (|(my & ((27'h1 << d) - 27'h1)));
        end

        if (sa == sb)
            sum = {1'b0, mx} + {1'b0, my_sh};
        else
            sum = {1'b0, mx} - {1'b0, my_sh};

        exp_n = {2'b00, ex};
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 5'(26 - i);
            norm  = sum[26:0] << lz;
            exp_n = exp_n - {5'd0, lz};
        end

        // Round to nearest even on guard/round/sticky.
        inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[26:3]} + {24'd0, inc};
        if (mant[24]) begin
            mant  = mant >> 1;
            exp_n = exp_n + 10'd1;
        end

        if (sum == 28'd0 || exp_n[9] || exp_n == 10'd0) begin
            Out    = '0;
            isZero = 1'b1;
        end else if (exp_n >= 10'd255)
            Out = {sx, 8'hFF, 23'd0};
        else
            Out = {sx, exp_n[7:0], mant[22:0]};
    end
endmodule

module fp32_accumulator #(
    parameter int LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FP32_ACC_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_zero
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [7:0] LEN_C = 8'(LEN);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] acc, acc_nxt, add_out;
    logic        acc_zero, acc_zero_nxt, add_zero, term_zero;

    FP_Adder_Subtractor32 u_add (
        .A      (acc),
        .B      (in_data),
        .sub    (1'b0),
        .Out    (add_out),
        .isZero (add_zero)
    );

    assign term_zero = (in_data[30:0] == 31'd0);
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_zero  = acc_zero;
    assign out_data  = acc_zero ? 32'h0 : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            acc_zero <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            acc_zero <= acc_zero_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        acc_zero_nxt = acc_zero;
        case (state)
            IDLE, ACC: begin
                if (in_valid) begin
                    // Zero terms only advance the count; an empty accumulator takes the term as-is.
                    if (!term_zero) begin
                        if (state == IDLE || acc_zero) begin
                            acc_nxt      = in_data;
                            acc_zero_nxt = 1'b0;
                        end else if (add_zero) begin
                            acc_nxt      = '0;
                            acc_zero_nxt = 1'b1;
                        end else begin
                            acc_nxt      = add_out;
                            acc_zero_nxt = 1'b0;
                        end
                    end
                    if (cnt == LEN_C - 8'd1) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + 8'd1;
                        state_nxt = ACC;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt    = IDLE;
                    acc_nxt      = '0;
                    acc_zero_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef FP32_ACC_FLUSH_EN
        if (flush) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            acc_nxt      = '0;
            acc_zero_nxt = 1'b1;
        end
`endif
    end
endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed bench for fp32_accumulator (LEN=4) with hand-computed FP32 sums.
module tb_fp32_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
`ifdef FP32_ACC_FLUSH_EN
    logic        flush = 1'b0;
`endif
    int total = 0;
    int bad   = 0;

    fp32_accumulator #(.LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FP32_ACC_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'h0);
        check({tag, "_out_zero"}, 32'(out_zero), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp, input logic z);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_zero"}, 32'(out_zero), 32'(z));
    endtask

    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1+1+1+1 = 4.0, consumer always ready
        out_ready = 1'b1;
        repeat (4) feed(32'h3F80_0000);
        check_result("ones", 32'h4080_0000, 1'b0);
        @(posedge clk);
        #1;
        check_idle("ones_after");
        out_ready = 1'b0;

        // 1 - 1 cancels to zero, then 2 loads directly, + 0.5 = 2.5
        feed(32'h3F80_0000);
        feed(32'hBF80_0000);
        feed(32'h4000_0000);
        feed(32'h3F00_0000);
        check_result("cancel", 32'h4020_0000, 1'b0);

        // Back-pressure: result held, offered input ignored
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_result("hold", 32'h4020_0000, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_idle("release");

        // All-zero terms
        repeat (4) feed(32'h0000_0000);
        check_result("zeros", 32'h0, 1'b1);
        drain();

        // 3 - 1 + 0 + 0.25 = 2.25
        feed(32'h4040_0000);
        feed(32'hBF80_0000);
        feed(32'h0000_0000);
        feed(32'h3E80_0000);
        check_result("mixed", 32'h4010_0000, 1'b0);
        drain();

        // 3 - 2.5 = 0.5 needs left normalisation
        feed(32'h4040_0000);
        feed(32'hC020_0000);
        feed(32'h0000_0000);
        feed(32'h0000_0000);
        check_result("norm", 32'h3F00_0000, 1'b0);
        drain();

        // Reset mid-accumulation discards the partial sum
        feed(32'h3F80_0000);
        feed(32'h3F80_0000);
        rst_n = 1'b0;
        #2;
        check_idle("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) feed(32'h4000_0000);
        check_result("post_rst", 32'h4100_0000, 1'b0);

        // Reset while a result is held drops it
        rst_n = 1'b0;
        #2;
        check_idle("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef FP32_ACC_FLUSH_EN
        repeat (3) feed(32'h4000_0000);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("flush");
        repeat (4) feed(32'h3F80_0000);
        check_result("post_flush", 32'h4080_0000, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
